// File: rtl/commit_trace_arbiter.sv
// commit_trace_arbiter
//   Collects up to four commit events per cycle (writeback, store, taken
//   branch, jalr) from the 5-stage core, buffers them in a show-ahead FIFO and
//   emits one trace entry per cycle. A stall request is raised while the FIFO
//   could not absorb a worst-case 4-event cycle. A trap switches to a drain
//   mode that empties the FIFO and then reports done.
//
// Ports
//   clk, reset_n                    clock, synchronous active-low reset
//   wb_* / st_* / br_* / jr_*       commit event inputs (valid + fields)
//   trap_in                         trap reached writeback (starts drain)
//   out_valid/out_ready             trace output handshake
//   out_type/pc/instr/addr/value/rd trace entry fields (0 when !out_valid)
//   stall_req                       core must stall
//   overflow, drop_cnt              sticky drop flag and dropped-event count
//   emit_cnt                        handshaken entry count
//   done                            drain complete
//   state_dbg                       FSM state (0=RUN, 1=DRAIN, 2=DONE)
//
// Handshake: an entry transfers on a rising edge where out_valid && out_ready.
// out_valid never depends on out_ready, and while out_valid && !out_ready the
// out_* fields hold their value.
module commit_trace_arbiter #(
  parameter int DEPTH = 8,
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             wb_valid,
  input  logic [XLEN-1:0]  wb_pc,
  input  logic [XLEN-1:0]  wb_instr,
  input  logic [4:0]       wb_rd,
  input  logic [XLEN-1:0]  wb_data,
  input  logic             st_valid,
  input  logic [XLEN-1:0]  st_pc,
  input  logic [XLEN-1:0]  st_instr,
  input  logic [XLEN-1:0]  st_addr,
  input  logic [XLEN-1:0]  st_data,
  input  logic             br_valid,
  input  logic [XLEN-1:0]  br_pc,
  input  logic [XLEN-1:0]  br_instr,
  input  logic             jr_valid,
  input  logic [XLEN-1:0]  jr_pc,
  input  logic [XLEN-1:0]  jr_instr,
  input  logic             trap_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [1:0]       out_type,
  output logic [XLEN-1:0]  out_pc,
  output logic [XLEN-1:0]  out_instr,
  output logic [XLEN-1:0]  out_addr,
  output logic [XLEN-1:0]  out_value,
  output logic [4:0]       out_rd,
  output logic             stall_req,
  output logic             overflow,
  output logic [CNT_W-1:0] drop_cnt,
  output logic [CNT_W-1:0] emit_cnt,
  output logic             done,
  output logic [1:0]       state_dbg
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CW    = PTR_W + 1;
  localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
  localparam logic [CW-1:0] STALL_TH  = CW'(DEPTH - 4);

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_DRAIN = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  typedef struct packed {
    logic [1:0]      typ;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] value;
    logic [4:0]      rd;
  } entry_t;

  state_t           state_q, state_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             overflow_q, overflow_d;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
  logic [CNT_W-1:0] emit_cnt_q, emit_cnt_d;
  entry_t           mem_q [DEPTH];
  entry_t           mem_d [DEPTH];

  entry_t           ev [4];
  logic [3:0]       ev_v;
  logic [CW-1:0]    space;
  logic [CW-1:0]    acc;
  logic [CW-1:0]    drop;
  logic             pop;
  entry_t           head;

  // Index order is the push order inside a cycle: wb, st, br, jr.
  always_comb begin
    ev_v  = {jr_valid, br_valid, st_valid, wb_valid};
    ev[0] = {2'd0, wb_pc, wb_instr, {XLEN{1'b0}}, wb_data, wb_rd};
    ev[1] = {2'd1, st_pc, st_instr, st_addr, st_data, 5'd0};
    ev[2] = {2'd2, br_pc, br_instr, {XLEN{1'b0}}, {XLEN{1'b0}}, 5'd0};
    ev[3] = {2'd3, jr_pc, jr_instr, {XLEN{1'b0}}, {XLEN{1'b0}}, 5'd0};
  end

  assign head      = mem_q[rd_ptr_q];
  assign out_valid = (count_q != '0) && (state_q != S_DONE);
  assign out_type  = out_valid ? head.typ   : '0;
  assign out_pc    = out_valid ? head.pc    : '0;
  assign out_instr = out_valid ? head.instr : '0;
  assign out_addr  = out_valid ? head.addr  : '0;
  assign out_value = out_valid ? head.value : '0;
  assign out_rd    = out_valid ? head.rd    : '0;

  assign stall_req = (state_q != S_RUN) || (count_q > STALL_TH);
  assign done      = (state_q == S_DONE);
  assign overflow  = overflow_q;
  assign drop_cnt  = drop_cnt_q;
  assign emit_cnt  = emit_cnt_q;
  assign state_dbg = state_q;

  always_comb begin
    mem_d      = mem_q;
    state_d    = state_q;
    acc        = '0;
    drop       = '0;
    pop        = out_valid && out_ready;
    // Free space is judged on the registered count only; a pop in this same
    // cycle does not make room for a push.
    space      = DEPTH_C - count_q;

    if (state_q == S_RUN) begin
      for (int i = 0; i < 4; i++) begin
        if (ev_v[i]) begin
          if (acc < space) begin
            mem_d[wr_ptr_q + acc[PTR_W-1:0]] = ev[i];
            acc = acc + CW'(1);
          end else begin
            drop = drop + CW'(1);
          end
        end
      end
    end

    wr_ptr_d   = wr_ptr_q + acc[PTR_W-1:0];
    rd_ptr_d   = rd_ptr_q + PTR_W'(pop);
    count_d    = count_q + acc - CW'(pop);
    overflow_d = overflow_q || (drop != '0);
    drop_cnt_d = drop_cnt_q + CNT_W'(drop);
    emit_cnt_d = emit_cnt_q + CNT_W'(pop);

    case (state_q)
      S_RUN:   if (trap_in) state_d = S_DRAIN;
      S_DRAIN: if (count_d == '0) state_d = S_DONE;
      S_DONE:  state_d = S_DONE;
      default: state_d = S_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= S_RUN;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
      emit_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
      emit_cnt_q <= emit_cnt_d;
    end
  end

  // Storage needs no reset: fields are masked to 0 whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: tb/tb_commit_trace_arbiter.sv
module tb_commit_trace_arbiter;
  localparam int DEPTH = 8;
  localparam int XLEN  = 32;
  localparam int CNT_W = 32;
  localparam int EW    = 2 + 4 * XLEN + 5;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             wb_valid = 1'b0, st_valid = 1'b0, br_valid = 1'b0, jr_valid = 1'b0;
  logic [XLEN-1:0]  wb_pc = '0, wb_instr = '0, wb_data = '0;
  logic [4:0]       wb_rd = '0;
  logic [XLEN-1:0]  st_pc = '0, st_instr = '0, st_addr = '0, st_data = '0;
  logic [XLEN-1:0]  br_pc = '0, br_instr = '0, jr_pc = '0, jr_instr = '0;
  logic             trap_in = 1'b0, out_ready = 1'b0;
  logic             out_valid, stall_req, overflow, done;
  logic [1:0]       out_type, state_dbg;
  logic [XLEN-1:0]  out_pc, out_instr, out_addr, out_value;
  logic [4:0]       out_rd;
  logic [CNT_W-1:0] drop_cnt, emit_cnt;
  logic [EW-1:0]    act;

  // Reference model: a queue of expected entries plus mode/flags/counters.
  logic [EW-1:0]    exp_q[$];
  int               m_mode;   // 0 run, 1 drain, 2 done
  logic             m_ovf;
  logic [CNT_W-1:0] m_drop, m_emit;

  int n_checks = 0;
  int n_fail   = 0;

  commit_trace_arbiter #(.DEPTH(DEPTH), .XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset_n(reset_n),
    .wb_valid(wb_valid), .wb_pc(wb_pc), .wb_instr(wb_instr), .wb_rd(wb_rd), .wb_data(wb_data),
    .st_valid(st_valid), .st_pc(st_pc), .st_instr(st_instr), .st_addr(st_addr), .st_data(st_data),
    .br_valid(br_valid), .br_pc(br_pc), .br_instr(br_instr),
    .jr_valid(jr_valid), .jr_pc(jr_pc), .jr_instr(jr_instr),
    .trap_in(trap_in),
    .out_valid(out_valid), .out_ready(out_ready), .out_type(out_type),
    .out_pc(out_pc), .out_instr(out_instr), .out_addr(out_addr), .out_value(out_value),
    .out_rd(out_rd), .stall_req(stall_req), .overflow(overflow),
    .drop_cnt(drop_cnt), .emit_cnt(emit_cnt), .done(done), .state_dbg(state_dbg)
  );

  assign act = {out_type, out_pc, out_instr, out_addr, out_value, out_rd};

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- model ----------------
  function automatic logic [EW-1:0] mk(input logic [1:0] t, input logic [31:0] pc,
                                       input logic [31:0] instr, input logic [31:0] addr,
                                       input logic [31:0] value, input logic [4:0] rd);
    return {t, pc, instr, addr, value, rd};
  endfunction

  function automatic bit m_valid();
    return (exp_q.size() != 0) && (m_mode != 2);
  endfunction

  function automatic logic [EW-1:0] m_word();
    return m_valid() ? exp_q[0] : '0;
  endfunction

  function automatic bit m_stall();
    return (m_mode != 0) || (exp_q.size() > DEPTH - 4);
  endfunction

  task automatic model_step();
    int sz0;
    int acc;
    bit pop;
    logic [EW-1:0] evs[$];
    if (!reset_n) begin
      exp_q.delete();
      m_mode = 0; m_ovf = 1'b0; m_drop = '0; m_emit = '0;
      return;
    end
    sz0 = exp_q.size();
    pop = m_valid() && out_ready;
    if (pop) begin
      void'(exp_q.pop_front());
      m_emit = m_emit + 1;
    end
    if (m_mode == 0) begin
      if (wb_valid) evs.push_back(mk(2'd0, wb_pc, wb_instr, 32'd0, wb_data, wb_rd));
      if (st_valid) evs.push_back(mk(2'd1, st_pc, st_instr, st_addr, st_data, 5'd0));
      if (br_valid) evs.push_back(mk(2'd2, br_pc, br_instr, 32'd0, 32'd0, 5'd0));
      if (jr_valid) evs.push_back(mk(2'd3, jr_pc, jr_instr, 32'd0, 32'd0, 5'd0));
      acc = 0;
      foreach (evs[i]) begin
        if (sz0 + acc < DEPTH) begin
          exp_q.push_back(evs[i]);
          acc++;
        end else begin
          m_drop = m_drop + 1;
          m_ovf  = 1'b1;
        end
      end
      if (trap_in) m_mode = 1;
    end else if (m_mode == 1 && exp_q.size() == 0) begin
      m_mode = 2;
    end
  endtask

  // ---------------- drivers ----------------
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    wb_valid = 0; st_valid = 0; br_valid = 0; jr_valid = 0; trap_in = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    out_ready = 0;
    reset_n = 0;
    tick();
    reset_n = 1;
  endtask

  task automatic drive_wb(input logic [31:0] pc, input logic [4:0] rd, input logic [31:0] data);
    wb_valid = 1; wb_pc = pc; wb_instr = 32'h00000013 | {20'd0, rd, 7'd0}; wb_rd = rd; wb_data = data;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    tick();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_checks++; if (act !== '0) begin n_fail++; $display("FAIL reset_fields got %h want 0", act); end
    n_checks++; if (stall_req !== 1'b0) begin n_fail++; $display("FAIL reset_stall got %b want 0", stall_req); end
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow got %b want 0", overflow); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
    n_checks++; if (drop_cnt !== '0) begin n_fail++; $display("FAIL reset_drop got %0d want 0", drop_cnt); end
    n_checks++; if (emit_cnt !== '0) begin n_fail++; $display("FAIL reset_emit got %0d want 0", emit_cnt); end
    n_checks++; if (state_dbg !== 2'd0) begin n_fail++; $display("FAIL reset_state got %0d want 0", state_dbg); end
  endtask

  task automatic test_single();
    logic [EW-1:0] want;
    do_reset();
    wb_valid = 1; wb_pc = 32'h10; wb_instr = 32'h00500093; wb_rd = 5'd1; wb_data = 32'd5;
    tick();
    clear_inputs();
    want = mk(2'd0, 32'h10, 32'h00500093, 32'd0, 32'd5, 5'd1);
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid got %b want 1", out_valid); end
    n_checks++; if (act !== want) begin n_fail++; $display("FAIL single_entry got %h want %h", act, want); end
    out_ready = 1;
    tick();
    out_ready = 0;
    n_checks++; if (emit_cnt !== 32'd1) begin n_fail++; $display("FAIL single_emit got %0d want 1", emit_cnt); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_empty got %b want 0", out_valid); end
  endtask

  task automatic test_four_events();
    logic [31:0] pcs [4];
    pcs[0] = 32'h20; pcs[1] = 32'h1C; pcs[2] = 32'h18; pcs[3] = 32'h14;
    do_reset();
    drive_wb(32'h20, 5'd2, 32'h11);
    st_valid = 1; st_pc = 32'h1C; st_instr = 32'h0AB02023; st_addr = 32'h100; st_data = 32'hAB;
    br_valid = 1; br_pc = 32'h18; br_instr = 32'h00208463;
    jr_valid = 1; jr_pc = 32'h14; jr_instr = 32'h000080E7;
    out_ready = 1;
    tick();
    clear_inputs();
    for (int k = 0; k < 4; k++) begin
      n_checks++; if (out_valid !== 1'b1 || out_type !== 2'(k) || out_pc !== pcs[k]) begin
        n_fail++; $display("FAIL four_order[%0d] got v=%b type=%0d pc=%h want v=1 type=%0d pc=%h", k, out_valid, out_type, out_pc, k, pcs[k]);
      end
      n_checks++; if (act !== m_word()) begin n_fail++; $display("FAIL four_entry[%0d] got %h want %h", k, act, m_word()); end
      tick();
    end
    out_ready = 0;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL four_empty got %b want 0", out_valid); end
    n_checks++; if (emit_cnt !== 32'd4) begin n_fail++; $display("FAIL four_emit got %0d want 4", emit_cnt); end
  endtask

  task automatic test_backpressure();
    do_reset();
    out_ready = 0;
    for (int i = 0; i < 9; i++) begin
      drive_wb(32'h100 + 32'(4 * i), 5'd3, 32'(i));
      tick();
      n_checks++; if (stall_req !== ((i + 1) > 4)) begin n_fail++; $display("FAIL bp_stall[%0d] got %b want %b", i, stall_req, (i + 1) > 4); end
      n_checks++; if (out_pc !== 32'h100) begin n_fail++; $display("FAIL bp_hold[%0d] got %h want 100", i, out_pc); end
    end
    clear_inputs();
    n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL bp_overflow got %b want 1", overflow); end
    n_checks++; if (drop_cnt !== 32'd1) begin n_fail++; $display("FAIL bp_drop got %0d want 1", drop_cnt); end
  endtask

  // Continues from a full FIFO left by test_backpressure.
  task automatic test_push_pop_full();
    out_ready = 1;
    drive_wb(32'h200, 5'd4, 32'h77);
    tick();
    clear_inputs();
    n_checks++; if (drop_cnt !== 32'd2) begin n_fail++; $display("FAIL full_pp_drop got %0d want 2", drop_cnt); end
    n_checks++; if (out_pc !== 32'h104) begin n_fail++; $display("FAIL full_pp_head got %h want 104", out_pc); end
    n_checks++; if (stall_req !== 1'b1) begin n_fail++; $display("FAIL full_pp_stall got %b want 1", stall_req); end
    for (int k = 0; k < 7; k++) begin
      n_checks++; if (out_pc !== 32'h104 + 32'(4 * k)) begin n_fail++; $display("FAIL full_pp_drain[%0d] got %h want %h", k, out_pc, 32'h104 + 32'(4 * k)); end
      tick();
    end
    out_ready = 0;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL full_pp_empty got %b want 0", out_valid); end
    n_checks++; if (emit_cnt !== 32'd8) begin n_fail++; $display("FAIL full_pp_emit got %0d want 8", emit_cnt); end
  endtask

  task automatic test_trap_drain();
    int popped;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive_wb(32'h40 + 32'(4 * i), 5'd5, 32'(100 + i));
      tick();
    end
    drive_wb(32'h4C, 5'd6, 32'd200);
    trap_in = 1;
    tick();
    trap_in = 0;
    out_ready = 1;
    drive_wb(32'h99, 5'd7, 32'd999);
    popped = 0;
    for (int c = 0; c < 10; c++) begin
      n_checks++; if (stall_req !== 1'b1) begin n_fail++; $display("FAIL trap_stall[%0d] got %b want 1", c, stall_req); end
      n_checks++; if (done !== (popped == 4)) begin n_fail++; $display("FAIL trap_done[%0d] got %b want %b", c, done, popped == 4); end
      if (popped < 4) begin
        n_checks++; if (out_valid !== 1'b1 || out_pc !== 32'h40 + 32'(4 * popped)) begin
          n_fail++; $display("FAIL trap_order[%0d] got v=%b pc=%h want v=1 pc=%h", popped, out_valid, out_pc, 32'h40 + 32'(4 * popped));
        end
        popped++;
      end
      tick();
    end
    clear_inputs();
    out_ready = 0;
    n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL trap_final_done got %b want 1", done); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL trap_final_valid got %b want 0", out_valid); end
    n_checks++; if (emit_cnt !== 32'd4) begin n_fail++; $display("FAIL trap_emit got %0d want 4", emit_cnt); end
    n_checks++; if (drop_cnt !== 32'd0) begin n_fail++; $display("FAIL trap_drop got %0d want 0", drop_cnt); end
    n_checks++; if (state_dbg !== 2'd2) begin n_fail++; $display("FAIL trap_state got %0d want 2", state_dbg); end
  endtask

  task automatic test_reset_mid_drain();
    do_reset();
    drive_wb(32'h60, 5'd8, 32'd1);
    tick();
    drive_wb(32'h64, 5'd8, 32'd2);
    trap_in = 1;
    tick();
    clear_inputs();
    n_checks++; if (state_dbg !== 2'd1) begin n_fail++; $display("FAIL mid_pre_state got %0d want 1", state_dbg); end
    reset_n = 0;
    tick();
    reset_n = 1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_valid got %b want 0", out_valid); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL mid_done got %b want 0", done); end
    n_checks++; if (stall_req !== 1'b0) begin n_fail++; $display("FAIL mid_stall got %b want 0", stall_req); end
    n_checks++; if (drop_cnt !== '0 || emit_cnt !== '0) begin n_fail++; $display("FAIL mid_counters got drop=%0d emit=%0d want 0 0", drop_cnt, emit_cnt); end
    n_checks++; if (state_dbg !== 2'd0) begin n_fail++; $display("FAIL mid_state got %0d want 0", state_dbg); end
  endtask

  task automatic test_random();
    int done_cycles;
    do_reset();
    done_cycles = 0;
    for (int c = 0; c < 800; c++) begin
      n_checks++; if (out_valid !== m_valid()) begin n_fail++; $display("FAIL rnd_valid[%0d] got %b want %b", c, out_valid, m_valid()); end
      n_checks++; if (act !== m_word()) begin n_fail++; $display("FAIL rnd_entry[%0d] got %h want %h", c, act, m_word()); end
      n_checks++; if (stall_req !== m_stall()) begin n_fail++; $display("FAIL rnd_stall[%0d] got %b want %b", c, stall_req, m_stall()); end
      n_checks++; if (overflow !== m_ovf) begin n_fail++; $display("FAIL rnd_overflow[%0d] got %b want %b", c, overflow, m_ovf); end
      n_checks++; if (done !== (m_mode == 2)) begin n_fail++; $display("FAIL rnd_done[%0d] got %b want %b", c, done, m_mode == 2); end
      n_checks++; if (drop_cnt !== m_drop) begin n_fail++; $display("FAIL rnd_drop[%0d] got %0d want %0d", c, drop_cnt, m_drop); end
      n_checks++; if (emit_cnt !== m_emit) begin n_fail++; $display("FAIL rnd_emit[%0d] got %0d want %0d", c, emit_cnt, m_emit); end
      wb_valid = 1'($urandom_range(0, 1)); wb_pc = $urandom; wb_instr = $urandom;
      wb_rd = 5'($urandom_range(1, 31)); wb_data = $urandom;
      st_valid = 1'($urandom_range(0, 1)); st_pc = $urandom; st_instr = $urandom;
      st_addr = $urandom; st_data = $urandom;
      br_valid = 1'($urandom_range(0, 1)); br_pc = $urandom; br_instr = $urandom;
      jr_valid = 1'($urandom_range(0, 1)); jr_pc = $urandom; jr_instr = $urandom;
      out_ready = ((c / 50) % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      trap_in = ($urandom_range(0, 79) == 0);
      reset_n = 1;
      if (m_mode == 2) done_cycles++;
      if (done_cycles > 3) begin
        reset_n = 0;
        done_cycles = 0;
      end
      tick();
    end
    clear_inputs();
    reset_n = 1;
  endtask

  initial begin
    test_reset();
    test_single();
    test_four_events();
    test_backpressure();
    test_push_pop_full();
    test_trap_drain();
    test_reset_mid_drain();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/commit_trace_arbiter.md
Name: commit_trace_arbiter

Overview:
- Collects up to four commit events per cycle from the 5-stage core and serialises them into a single-entry-per-cycle trace stream with a valid/ready handshake:
  - register writeback (MEMWB)
  - data-memory store (EXMEM)
  - taken branch
  - jalr
- Buffers events in a FIFO and raises a stall request to the core's hazard logic before the FIFO can overflow.
- On trap (ecall/ebreak) it drains the FIFO and signals completion.
- Sits between the core's pipeline registers and the trace checker/logger.

Parameters:
- DEPTH, 8, FIFO entries; power of 2, at least 4.
- XLEN, 32, width of the pc, instr, addr and value fields.
- CNT_W, 32, width of the emitted and dropped counters.

Ports:
- clk  in  1  system clock, rising edge
- reset_n  in  1  synchronous, active-low reset
- wb_valid  in  1  register writeback commit (caller guarantees rd != 0)
- wb_pc, wb_instr  in  XLEN  writeback pc and instruction
- wb_rd  in  5  writeback destination register
- wb_data  in  XLEN  writeback value
- st_valid  in  1  store commit
- st_pc, st_instr, st_addr, st_data  in  XLEN  store pc, instruction, address and data
- br_valid  in  1  taken-branch commit
- br_pc, br_instr  in  XLEN  branch pc and instruction
- jr_valid  in  1  jalr commit
- jr_pc, jr_instr  in  XLEN  jalr pc and instruction
- trap_in  in  1  trap reached writeback
- out_valid  out  1  trace entry available
- out_ready  in  1  consumer accepts the entry
- out_type  out  2  0=reg/load, 1=store, 2=branch, 3=jalr
- out_pc, out_instr, out_addr, out_value  out  XLEN  entry fields
- out_rd  out  5  entry destination register
- stall_req  out  1  core must stall
- overflow  out  1  sticky; an event was dropped
- drop_cnt  out  CNT_W  number of dropped events
- emit_cnt  out  CNT_W  number of handshaken entries
- done  out  1  drain complete

Behaviour:
- Reset (reset_n=0 at a rising edge):
  - Pointers and count go to 0; state goes to RUN.
  - All outputs are 0 (out_valid, stall_req, overflow, done, both counters, all data fields).
- Per-cycle event count n = wb_valid + st_valid + br_valid + jr_valid (0..4).
  - Push order within the cycle is fixed: wb, st, br, jr. Earlier in the order means earlier in the stream.
- Entry field mapping:
  - wb: addr=0, value=wb_data, rd=wb_rd.
  - st: addr=st_addr, value=st_data, rd=0.
  - br/jr: addr=0, value=0, rd=0.
- Space check uses the registered count at the start of the cycle. A pop in the same cycle is NOT credited.
  - Events are accepted in push order while count+k < DEPTH.
  - The remainder is dropped: overflow is set and drop_cnt increases by the number dropped, both visible the next cycle.
- Pop: when out_valid && out_ready, the head advances and emit_cnt increments.
  - Push and pop may occur in the same cycle; count_next = count + accepted − popped.
- Latency: an event presented in cycle N appears at the FIFO head (out_valid=1) in cycle N+1 if the FIFO was empty.
  - The FIFO is show-ahead: out_* are driven combinationally from head storage. out_valid = (count != 0) && state != DONE.
- Holding: out_* stay stable while out_valid && !out_ready.
- Wrap-around: pointers are log2(DEPTH) bits and wrap modulo DEPTH. count is log2(DEPTH)+1 bits.
- stall_req = (count > DEPTH−4), combinational from registered count. It guarantees room for a worst-case 4-event cycle.
- FSM:
  - RUN: accept events. trap_in=1 moves to DRAIN; events in that same cycle are still accepted.
  - DRAIN: all *_valid inputs are ignored (not counted as dropped) and stall_req is forced to 1. Pops continue. When count==0 (after any pop this cycle), move to DONE.
  - DONE: done=1 and stall_req=1, held until reset. out_valid=0.
- trap_in in DRAIN or DONE is ignored.
- Reset mid-drain, or with a full FIFO, discards all contents the next cycle.
- Counters wrap at 2^CNT_W.

Test Plan:
- Single event: wb_valid, pc=0x10, instr=0x00500093, rd=1, data=5 -> next cycle out_valid=1, type=0, rd=1, value=5; with out_ready=1, emit_cnt=1 and out_valid=0 in the following cycle.
- Four events in one cycle: wb pc=0x20, st pc=0x1C addr=0x100 data=0xAB, br pc=0x18, jr pc=0x14, with out_ready=1 -> four consecutive entries of type 0,1,2,3, then out_valid=0; emit_cnt=4.
- Backpressure, DEPTH=8: out_ready=0, one wb event per cycle -> stall_req rises the cycle after count reaches 5; pushing 9 events gives count=8, overflow=1, drop_cnt=1; out_pc holds the first pc throughout.
- Simultaneous push/pop at count=8, out_ready=1, one event pushed -> event dropped (pop not credited), drop_cnt +1, count becomes 7.
- Trap drain: 3 entries queued, trap_in=1 with wb_valid=1, then out_ready=1 -> 4 entries emitted in order; any wb_valid asserted during DRAIN is ignored; done=1 the cycle after the last pop; stall_req=1 from DRAIN onward.
- Reset mid-drain: reset_n=0 for one cycle while 2 entries are queued -> next cycle out_valid=0, done=0, stall_req=0, both counters=0, state RUN.
